if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents if_pc_4/if_instruction plus a valid flag to the IF/ID register, honours the ID-stage stall, and takes branch/jump redirects.
- A one-entry skid buffer absorbs a memory response that arrives while ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/address width; instruction width fixed at 32.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_shouldStall  in  1  ID stall; output slot is held when high.
- redirect_valid  in  1  one-cycle pulse: flush and fetch from redirect_pc.
- redirect_pc  in  ADDR_W  redirect target, word-aligned.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req high.
- imem_ack  in  1  response valid; counts only while imem_req high.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_valid  out  1  output slot holds a real instruction.
- if_pc_4  out  ADDR_W  fetched PC + 4.
- if_instruction  out  32  fetched word; 32'h0 (NOP bubble) when if_valid=0.

Behaviour:
- Reset (reset and clock as decided above):
  - pc=RESET_PC, state=IDLE, skid empty.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc_4=0, if_instruction=0.
- Reset mid-transaction abandons the request. A late ack with imem_req=0 is ignored.
- Slot consumption: the slot is consumed at any edge where id_shouldStall=0. It is then reloaded from skid, else from the same-cycle ack, else becomes bubble (if_valid=0, if_instruction=0, if_pc_4 unchanged).
- States:
  - IDLE -> REQ unconditionally. Purpose: one reset bubble.
  - REQ: imem_req=1, imem_addr=pc. On ack: data goes to the slot if the slot is empty or being consumed, else to skid. Set pc<=pc+4, written entry's pc_4=pc+4. Stay in REQ if skid stays empty, else go to HOLD.
  - HOLD: imem_req=0; entered when skid is full. Leave to REQ the cycle after skid drains.
  - DRAIN: entered on redirect while imem_req=1 and no ack. Keeps imem_req=1 with the old address and discards the ack data. Then goes to REQ at the latched target pc.
- Redirect has priority over all other transitions:
  - Clears the slot (if_valid=0, if_instruction=0) and the skid.
  - Loads pc<=redirect_pc.
  - Redirect with a same-cycle ack: data dropped; REQ at redirect_pc next cycle.
  - Redirect while stalled: slot still cleared, since ID is being flushed.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle with no bubbles.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0 silently.
- Ack while the slot and skid are both full cannot occur, because req is low in HOLD.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each accepted, non-discarded ack.
  - perf_stall_cnt increments each cycle with if_valid=1 and id_shouldStall=1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package if_pkg holds:
  - state enum {IDLE, REQ, HOLD, DRAIN};
  - NOP_INSTR=32'h0; PC_STEP=4;
  - the fetch entry typedef {pc_4, instr}.
- One sub-module: if_skid_entry. One-entry buffer with push/pop/flush and a full flag; used for the skid.

Test Plan:
- Reset, then zero-wait memory returning 32'h1000_0000+addr:
  - cycle 1 is a bubble;
  - then if_pc_4=4,8,12,… on consecutive cycles with if_valid=1.
- Ack latency 2, no stall:
  - imem_addr stays 0 for 3 cycles with imem_req=1;
  - if_valid pulses every 3rd cycle; if_pc_4=4, then 8.
- Stall for 5 cycles with zero-wait memory:
  - slot holds pc_4=8; skid captures pc_4=12; imem_req=0 in HOLD.
  - After release, slot shows 12 then 16 on consecutive cycles, with no duplicates or loss.
- Redirect to 32'h200 during an ack-latency-3 wait:
  - imem_addr holds the old address until ack, and that data is discarded;
  - next request is at 0x200; next valid output has if_pc_4=0x204.
- Redirect coincident with ack and a stall:
  - if_valid=0, if_instruction=0 next cycle;
  - following fetch at redirect_pc.
- Reset asserted in REQ with ack pending:
  - next cycle all outputs are at reset values, and the ack that arrives then is ignored;
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_pkg
//  Purpose  : Shared types and constants for the instruction-fetch stage:
//             FSM state encodings, the NOP bubble word, the PC step, and
//             the fetch-entry record (pc_4, instr) held in the output slot
//             and the skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Fetch FSM state encodings.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t REQ   = 2'd1;
    localparam state_t HOLD  = 2'd2;
    localparam state_t DRAIN = 2'd3;

    // Word presented to ID when the slot holds no real instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_STEP = 4;

    // Fetch entry for the default 32-bit address width.
    typedef struct packed {
        logic [31:0] pc_4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_skid_entry.sv
`default_nettype none
// ============================================================================
//  Module   : if_skid_entry
//  Purpose  : One-entry holding buffer. Captures an entry on push, releases
//             it on pop, and is emptied by flush or reset. Used as the skid
//             buffer behind the IF/ID output slot.
//  Ports    : clock, reset      - clock, synchronous active-high reset
//             i_push / i_data   - write an entry (only issued while empty)
//             i_pop             - release the held entry
//             i_flush           - discard the held entry
//             o_full / o_data   - occupancy flag and held entry
//  Revision : 1.0 - initial release
// ============================================================================
module if_skid_entry
    import if_pkg::*;
#(
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   i_push,
    input  logic   i_pop,
    input  logic   i_flush,
    input  ENTRY_T i_data,
    output logic   o_full,
    output ENTRY_T o_data
);

    logic   r_full;
    ENTRY_T r_data;

    // Flush wins over push so a redirect never leaves stale data behind.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_push && !i_flush) begin
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Purpose  : Instruction-fetch stage, producer side of the IF/ID register.
//             Owns the PC, fetches words over a req/ack handshake, presents
//             {if_valid, if_pc_4, if_instruction} to ID, honours the ID
//             stall, and takes branch/jump redirects. A one-entry skid
//             buffer absorbs a response that lands while ID is stalled.
//  Ports    : clock, reset                   - clock, sync active-high reset
//             id_shouldStall                 - hold the output slot
//             redirect_valid / redirect_pc   - flush and refetch at target
//             imem_req/addr/ack/rdata        - instruction memory handshake
//             if_valid/if_pc_4/if_instruction - output slot to IF/ID
//  Options  : IF_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_shouldStall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc_4,
    output logic [31:0]       if_instruction
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc_4;
        logic [31:0]       instr;
    } entry_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drain_addr;
    logic              r_valid;
    entry_t            r_slot;

    logic              w_ack;
    logic              w_take_slot;
    logic              w_fetch_ok;
    logic [ADDR_W-1:0] w_pc_next;
    entry_t            w_new;
    logic              w_skid_full;
    entry_t            w_skid_data;

    // An ack only counts while a request is outstanding.
    assign w_ack       = imem_ack && imem_req;
    // The slot may be rewritten when it is empty or ID consumes it this edge.
    assign w_take_slot = !r_valid || !id_shouldStall;
    // Responses in DRAIN or under a redirect are discarded.
    assign w_fetch_ok  = w_ack && (r_state == REQ) && !redirect_valid;
    assign w_pc_next   = r_pc + ADDR_W'(PC_STEP);
    assign w_new       = '{pc_4: w_pc_next, instr: imem_rdata};

    if_skid_entry #(
        .ENTRY_T (entry_t)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_fetch_ok && !w_take_slot),
        .i_pop   (w_take_slot && w_skid_full),
        .i_flush (redirect_valid),
        .i_data  (w_new),
        .o_full  (w_skid_full),
        .o_data  (w_skid_data)
    );

    // Fetch FSM and PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
            // An unanswered request must complete at its old address before
            // the target can be fetched; its data is thrown away in DRAIN.
            if (imem_req && !imem_ack) begin
                r_state <= DRAIN;
                if (r_state == REQ) begin
                    r_drain_addr <= r_pc;
                end
            end else begin
                r_state <= REQ;
            end
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (w_ack) begin
                        r_pc <= w_pc_next;
                        if (!w_take_slot) begin
                            r_state <= HOLD;
                        end
                    end
                end
                // Slot is valid in HOLD, so the skid pops exactly when ID
                // consumes; resume fetching on that same edge.
                HOLD:  if (!id_shouldStall) r_state <= REQ;
                DRAIN: if (w_ack) r_state <= REQ;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output slot: reload priority is skid, then same-cycle ack, then bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_slot  <= '{pc_4: '0, instr: NOP_INSTR};
        end else if (redirect_valid) begin
            r_valid      <= 1'b0;
            r_slot.instr <= NOP_INSTR;
        end else if (w_take_slot) begin
            if (w_skid_full) begin
                r_valid <= 1'b1;
                r_slot  <= w_skid_data;
            end else if (w_fetch_ok) begin
                r_valid <= 1'b1;
                r_slot  <= w_new;
            end else begin
                r_valid      <= 1'b0;
                r_slot.instr <= NOP_INSTR;
            end
        end
    end

    assign imem_req       = (r_state == REQ) || (r_state == DRAIN);
    assign imem_addr      = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign if_valid       = r_valid;
    assign if_pc_4        = r_slot.pc_4;
    assign if_instruction = r_slot.instr;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch_ok) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (r_valid && id_shouldStall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire
